// File: rtl/riscv_decode_pkg.sv
// Shared RV32I decode constants: opcode classes, ALU codes, B-operand selects.
// Also holds the funct3 -> ALU operation mapping shared by R and I-ALU forms.
package riscv_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRX = 3'b111;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [2:0] alu_op(
    input logic [2:0] f3,
    input logic       sub
  );
    logic [2:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:         op = sub ? ALU_SUB : ALU_ADD;
      3'b111:         op = ALU_AND;
      3'b110:         op = ALU_OR;
      3'b100:         op = ALU_XOR;
      3'b010, 3'b011: op = ALU_SLT;
      3'b001:         op = ALU_SLL;
      default:        op = ALU_SRX;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator.
// Selects the immediate format from the opcode; unknown opcodes give zero.
module imm_gen
  import riscv_decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  logic [31:0] i;
  assign i = instr_i;

  always_comb begin
    imm_o = '0;
    case (i[6:0])
      OP_IALU, OP_LOAD, OP_JALR:
        imm_o = {{20{i[31]}}, i[31:20]};
      OP_STORE:
        imm_o = {{20{i[31]}}, i[31:25], i[11:7]};
      OP_BRANCH:
        imm_o = {{19{i[31]}}, i[31], i[7],
                 i[30:25], i[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm_o = {i[31:12], 12'b0};
      OP_JAL:
        imm_o = {{11{i[31]}}, i[31], i[19:12],
                 i[20], i[30:21], 1'b0};
      default:
        imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: control decode plus a single output register.
// Every output is captured one clk after the instruction is presented.
module decode_unit
  import riscv_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Cond_Chk_reg,
  input  logic [31:0] instruction,
  output logic [6:0]  opcode_reg,
  output logic [2:0]  funct3_reg,
  output logic [6:0]  funct7_reg,
  output logic [4:0]  rs1_reg,
  output logic [4:0]  rs2_reg,
  output logic [4:0]  rd_reg,
  output logic [31:0] Imm_reg,
  output logic        IorD_reg,
  output logic        MemWrite_reg,
  output logic        MtoR_reg,
  output logic        IRWrite_reg,
  output logic        RegWrite_reg,
  output logic        Branch_reg,
  output logic        PCWrite_reg,
  output logic        PCSel_reg,
  output logic        AluSrcA_reg,
  output logic [1:0]  AluSrcB_reg,
  output logic [2:0]  AluControl_reg
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        rd_nz;
  logic [31:0] imm_d;

  assign op    = instruction[6:0];
  assign f3    = instruction[14:12];
  assign f7    = instruction[31:25];
  assign rd_nz = |instruction[11:7];

  imm_gen u_imm_gen (
    .instr_i (instruction),
    .imm_o   (imm_d)
  );

  logic is_r, is_i, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_auipc, legal;

  assign is_r     = (op == OP_R);
  assign is_i     = (op == OP_IALU);
  assign is_ld    = (op == OP_LOAD);
  assign is_st    = (op == OP_STORE);
  assign is_br    = (op == OP_BRANCH);
  assign is_jal   = (op == OP_JAL);
  assign is_jalr  = (op == OP_JALR);
  assign is_lui   = (op == OP_LUI);
  assign is_auipc = (op == OP_AUIPC);
  assign legal    = is_r | is_i | is_ld | is_st | is_br |
                    is_jal | is_jalr | is_lui | is_auipc;

  logic       iord_d, memw_d, mtor_d, regw_d;
  logic       br_d, pcsel_d, srca_d;
  logic [1:0] srcb_d;
  logic [2:0] alu_d;

  always_comb begin
    iord_d  = 1'b0;
    memw_d  = 1'b0;
    mtor_d  = 1'b0;
    regw_d  = 1'b0;
    br_d    = 1'b0;
    pcsel_d = 1'b0;
    srca_d  = 1'b0;
    srcb_d  = SRCB_RS2;
    alu_d   = ALU_ADD;
    unique case (1'b1)
      is_r: begin
        regw_d = rd_nz;
        alu_d  = alu_op(f3, f7[5]);
      end
      is_i: begin
        regw_d = rd_nz;
        srcb_d = SRCB_IMM;
        alu_d  = alu_op(f3, 1'b0);
      end
      is_ld: begin
        iord_d = 1'b1;
        mtor_d = 1'b1;
        regw_d = rd_nz;
        srcb_d = SRCB_IMM;
      end
      is_st: begin
        iord_d = 1'b1;
        memw_d = 1'b1;
        srcb_d = SRCB_IMM;
      end
      is_br: begin
        br_d    = 1'b1;
        pcsel_d = Cond_Chk_reg;
        srca_d  = 1'b1;
        srcb_d  = SRCB_IMM;
        alu_d   = ALU_SUB;
      end
      is_jal: begin
        regw_d  = rd_nz;
        pcsel_d = 1'b1;
        srca_d  = 1'b1;
        srcb_d  = SRCB_FOUR;
      end
      is_jalr: begin
        regw_d  = rd_nz;
        pcsel_d = 1'b1;
        srcb_d  = SRCB_FOUR;
      end
      is_lui: begin
        regw_d = rd_nz;
        srcb_d = SRCB_IMM;
      end
      is_auipc: begin
        regw_d = rd_nz;
        srca_d = 1'b1;
        srcb_d = SRCB_IMM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode_reg     <= '0;
      funct3_reg     <= '0;
      funct7_reg     <= '0;
      rs1_reg        <= '0;
      rs2_reg        <= '0;
      rd_reg         <= '0;
      Imm_reg        <= '0;
      IorD_reg       <= 1'b0;
      MemWrite_reg   <= 1'b0;
      MtoR_reg       <= 1'b0;
      IRWrite_reg    <= 1'b0;
      RegWrite_reg   <= 1'b0;
      Branch_reg     <= 1'b0;
      PCWrite_reg    <= 1'b0;
      PCSel_reg      <= 1'b0;
      AluSrcA_reg    <= 1'b0;
      AluSrcB_reg    <= '0;
      AluControl_reg <= '0;
    end else begin
      opcode_reg     <= op;
      funct3_reg     <= f3;
      funct7_reg     <= f7;
      rs1_reg        <= instruction[19:15];
      rs2_reg        <= instruction[24:20];
      rd_reg         <= instruction[11:7];
      Imm_reg        <= imm_d;
      IorD_reg       <= iord_d;
      MemWrite_reg   <= memw_d;
      MtoR_reg       <= mtor_d;
      IRWrite_reg    <= legal;
      RegWrite_reg   <= regw_d;
      Branch_reg     <= br_d;
      PCWrite_reg    <= legal;
      PCSel_reg      <= pcsel_d;
      AluSrcA_reg    <= srca_d;
      AluSrcB_reg    <= srcb_d;
      AluControl_reg <= alu_d;
    end
  end

endmodule

// File: tb/tb_decode_unit.sv
// Directed-vector bench for decode_unit.
// Control strobes are compared as one packed word built by ctl().
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cond;
  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        iord, memw, mtor, irw, regw, br, pcw, pcsel, srca;
  logic [1:0]  srcb;
  logic [2:0]  aluc;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_unit dut (
    .clk            (clk),
    .reset          (reset),
    .Cond_Chk_reg   (cond),
    .instruction    (instr),
    .opcode_reg     (opcode),
    .funct3_reg     (funct3),
    .funct7_reg     (funct7),
    .rs1_reg        (rs1),
    .rs2_reg        (rs2),
    .rd_reg         (rd),
    .Imm_reg        (imm),
    .IorD_reg       (iord),
    .MemWrite_reg   (memw),
    .MtoR_reg       (mtor),
    .IRWrite_reg    (irw),
    .RegWrite_reg   (regw),
    .Branch_reg     (br),
    .PCWrite_reg    (pcw),
    .PCSel_reg      (pcsel),
    .AluSrcA_reg    (srca),
    .AluSrcB_reg    (srcb),
    .AluControl_reg (aluc)
  );

  // {iord,memw,mtor,irw,regw,br,pcw,pcsel,srca,srcb,aluc}
  function automatic logic [31:0] ctl(
    input logic a_iord, a_memw, a_mtor, a_irw, a_regw,
    input logic a_br, a_pcw, a_pcsel, a_srca,
    input logic [1:0] a_srcb,
    input logic [2:0] a_aluc
  );
    return {18'b0, a_iord, a_memw, a_mtor, a_irw, a_regw,
            a_br, a_pcw, a_pcsel, a_srca, a_srcb, a_aluc};
  endfunction

  function automatic logic [31:0] obs();
    return ctl(iord, memw, mtor, irw, regw, br, pcw,
               pcsel, srca, srcb, aluc);
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [31:0] w, input logic c);
    @(negedge clk);
    instr = w;
    cond  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cond  = 1'b0;
    instr = 32'h0002A5A3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", obs(), 32'h0);
    check("rst_imm", imm, 32'h0);
    check("rst_rd", {27'b0, rd}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // sw x0,11(x5)
    apply(32'h0002A5A3, 1'b1);
    check("sw_op", {25'b0, opcode}, 32'h23);
    check("sw_f3", {29'b0, funct3}, 32'h2);
    check("sw_rs1", {27'b0, rs1}, 32'd5);
    check("sw_rs2", {27'b0, rs2}, 32'd0);
    check("sw_rd", {27'b0, rd}, 32'd11);
    check("sw_imm", imm, 32'd11);
    check("sw_ctl", obs(),
          ctl(1, 1, 0, 1, 0, 0, 1, 0, 0, 2'b01, 3'b000));

    // add / sub
    apply(32'h002081B3, 1'b0);
    check("add_rd", {27'b0, rd}, 32'd3);
    check("add_rs", {22'b0, rs1, rs2}, {22'b0, 5'd1, 5'd2});
    check("add_imm", imm, 32'h0);
    check("add_ctl", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b00, 3'b000));
    apply(32'h402081B3, 1'b0);
    check("sub_alu", {29'b0, aluc}, 32'd1);
    check("sub_f7", {25'b0, funct7}, 32'h20);

    // slt x3,x1,x2
    apply(32'h0020A1B3, 1'b0);
    check("slt_alu", {29'b0, aluc}, 32'd5);

    // beq x1,x2,+8 taken / not taken
    apply(32'h00208463, 1'b1);
    check("beq_imm", imm, 32'd8);
    check("beqT_ctl", obs(),
          ctl(0, 0, 0, 1, 0, 1, 1, 1, 1, 2'b01, 3'b001));
    apply(32'h00208463, 1'b0);
    check("beqN_ctl", obs(),
          ctl(0, 0, 0, 1, 0, 1, 1, 0, 1, 2'b01, 3'b001));

    // addi x1,x0,-1 and rd=0 variant
    apply(32'hFFF00093, 1'b0);
    check("addi_imm", imm, 32'hFFFFFFFF);
    check("addi_ctl", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b01, 3'b000));
    apply(32'hFFF00013, 1'b0);
    check("addi0_rw", {31'b0, regw}, 32'd0);

    // addi with imm bit 30 set must stay ADD
    apply(32'hC0000093, 1'b0);
    check("addiN_imm", imm, 32'hFFFFFC00);
    check("addiN_alu", {29'b0, aluc}, 32'd0);

    // srai x1,x1,3
    apply(32'h4030D093, 1'b0);
    check("srai_alu", {29'b0, aluc}, 32'd7);
    check("srai_f7", {25'b0, funct7}, 32'h20);

    // lw x1,4(x2)
    apply(32'h00412083, 1'b0);
    check("lw_imm", imm, 32'd4);
    check("lw_ctl", obs(),
          ctl(1, 0, 1, 1, 1, 0, 1, 0, 0, 2'b01, 3'b000));

    // jal x1,-4
    apply(32'hFFDFF0EF, 1'b0);
    check("jal_imm", imm, 32'hFFFFFFFC);
    check("jal_ctl", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 1, 1, 2'b10, 3'b000));

    // jalr x1,8(x2)
    apply(32'h008100E7, 1'b0);
    check("jalr_imm", imm, 32'd8);
    check("jalr_ctl", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 1, 0, 2'b10, 3'b000));

    // lui x1,0x12345 / auipc x1,0x12345
    apply(32'h123450B7, 1'b0);
    check("lui_imm", imm, 32'h12345000);
    check("lui_ctl", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b01, 3'b000));
    apply(32'h12345097, 1'b0);
    check("auipc_ctl", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 0, 1, 2'b01, 3'b000));

    // illegal opcode 0x7F, fields still pass through
    apply(32'hFFFFFFFF, 1'b1);
    check("ill_ctl", obs(), 32'h0);
    check("ill_imm", imm, 32'h0);
    check("ill_op", {25'b0, opcode}, 32'h7F);
    check("ill_rd", {27'b0, rd}, 32'd31);

    // async reset mid-cycle after a valid decode
    apply(32'h0002A5A3, 1'b0);
    check("pre_rst", obs(),
          ctl(1, 1, 0, 1, 0, 0, 1, 0, 0, 2'b01, 3'b000));
    #1;
    reset = 1'b0;
    #1;
    check("arst_ctl", obs(), 32'h0);
    check("arst_imm", imm, 32'h0);
    check("arst_rs1", {27'b0, rs1}, 32'h0);
    instr = 32'h002081B3;
    @(posedge clk);
    #1;
    check("hold_ctl", obs(), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_ctl", obs(), 32'h0);
    @(posedge clk);
    #1;
    check("rel_rd", {27'b0, rd}, 32'd3);
    check("rel_ctl2", obs(),
          ctl(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b00, 3'b000));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 Cond_Chk_reg  in  1  branch comparison result from the datapath (1 = condition true).
REQ-004 instruction  in  32  RV32I instruction word to decode.
REQ-005 opcode_reg/funct3_reg/funct7_reg  out  7/3/7  registered copies of instruction[6:0]/[14:12]/[31:25].
REQ-006 rs1_reg/rs2_reg/rd_reg  out  5 each  registered copies of instruction[19:15]/[24:20]/[11:7].
REQ-007 Imm_reg  out  32  registered sign-extended immediate.
REQ-008 IorD_reg, MemWrite_reg, MtoR_reg, IRWrite_reg, RegWrite_reg, Branch_reg, PCWrite_reg, PCSel_reg, AluSrcA_reg  out  1 each  registered control strobes.
REQ-009 AluSrcB_reg  out  2  ALU B-operand select; AluControl_reg  out  3  ALU operation.

Function
REQ-010 All outputs SHALL be registered: each value is decoded combinationally from instruction and Cond_Chk_reg and captured on the next rising clk (1-cycle latency); no other state exists.
REQ-011 Opcode classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other value is ILLEGAL.
REQ-012 Imm: I-type (I-ALU, LOAD, JALR) {20{i[31]},i[31:20]}; S {i[31:25],i[11:7]}; B {i[31],i[7],i[30:25],i[11:8],0}; U {i[31:12],12'b0}; J {i[31],i[19:12],i[20],i[30:21],0}; all sign-extended to 32 bits; R/ILLEGAL -> 0.
REQ-013 AluControl: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL/SRA (funct7[5] on funct7_reg distinguishes).
REQ-014 R: funct3 000 -> SUB if funct7[5], else ADD; 111 AND; 110 OR; 100 XOR; 010/011 SLT; 001 SLL; 101 SRL/SRA. I-ALU: same mapping, except funct3 000 is always ADD.
REQ-015 LOAD/STORE/JAL/JALR/LUI/AUIPC -> ADD; BRANCH -> SUB; ILLEGAL -> 000.
REQ-016 AluSrcA: 0 = rs1, 1 = PC; SHALL be 1 for AUIPC, JAL, BRANCH.
REQ-017 AluSrcB: 00 rs2 (R), 01 Imm (I-ALU, LOAD, STORE, LUI, AUIPC, BRANCH target), 10 constant 4 (JAL, JALR link), 11 unused/never driven.
REQ-018 IorD = 1 (data address) for LOAD/STORE, else 0; MemWrite = 1 only for STORE; MtoR = 1 only for LOAD.
REQ-019 RegWrite = 1 for R, I-ALU, LOAD, JAL, JALR, LUI, AUIPC when rd != 0; else 0.
REQ-020 Branch = 1 only for BRANCH.
REQ-021 PCSel = (BRANCH and Cond_Chk_reg) or JAL or JALR; 1 selects computed target, 0 selects PC+4.
REQ-022 PCWrite = 1 and IRWrite = 1 for every recognised opcode; ILLEGAL -> both 0 (pipeline holds).
REQ-023 ILLEGAL: all control strobes 0, AluSrcB 00, AluControl 000, Imm 0; field outputs still pass through.

Reset
REQ-024 While reset = 0, all outputs SHALL asynchronously go to 0 and hold; first decode is captured on the first rising clk with reset = 1.
REQ-025 Reset asserted mid-operation SHALL clear outputs immediately, with no partial update on release.

Structure
REQ-026 Opcode constants, AluControl codes, and AluSrcB codes SHALL live in a shared package (e.g. riscv_decode_pkg).
REQ-027 Immediate generation SHALL be one sub-module imm_gen (combinational, instruction in, 32-bit Imm out); control decode and output register remain in decode_unit.

Verification
REQ-028 0x0002A5A3 (sw x0,11(x5)), Cond_Chk=1 -> opcode 0100011, funct3 010, rs1 5, rs2 0, rd 11, Imm 11, MemWrite 1, IorD 1, AluSrcB 01, AluControl 000, RegWrite 0, PCSel 0, PCWrite 1.
REQ-029 0x002081B3 (add x3,x1,x2) -> rd 3, rs1 1, rs2 2, RegWrite 1, AluSrcB 00, AluControl 000; with funct7 0100000 (0x402081B3) -> AluControl 001.
REQ-030 0x00208463 (beq x1,x2,+8): Cond_Chk=1 -> Branch 1, PCSel 1, Imm 8, AluControl 001; Cond_Chk=0 -> PCSel 0.
REQ-031 0xFFF00093 (addi x1,x0,-1) -> Imm 0xFFFFFFFF, AluSrcB 01, RegWrite 1; same with rd=0 (0xFFF00013) -> RegWrite 0.
REQ-032 Opcode 0x7F -> all strobes 0, PCWrite 0, IRWrite 0, Imm 0.
REQ-033 Drive reset low between clock edges after a valid decode -> outputs 0 immediately; release -> correct values one rising edge later.
